// File: rtl/debounce_multi_pkg.sv
// Shared timing constants, sizing helper and per-channel output bundle
// for the front-panel button conditioner.
package debounce_multi_pkg;

  // 100 MHz clock with a 1 kHz tick: 16 ms filter window, ~1 s long press
  localparam int DEFAULT_STABLE_CYCLES = 16;
  localparam int DEFAULT_LONG_CYCLES   = 1024;

  // Number of bits needed to count 0..value-1, never less than one bit
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  // Everything one button channel reports back to the top level
  typedef struct packed {
    logic level;
    logic pressPulse;
    logic releasePulse;
    logic longPulse;
  } chanOut_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser chain, time-based stability filter
// with press/release pulses, and a one-shot long-press detector.
module debounce_channel
  import debounce_multi_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     tick,
  input  logic     buttonPress,
  output chanOut_t chanOut
);

  localparam int STABLE_W = clog2(STABLE_CYCLES);
  localparam int LONG_W   = clog2(LONG_CYCLES + 1);

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [STABLE_W-1:0] STABLE_ONE  = STABLE_W'(1);
  localparam logic [LONG_W-1:0]   LONG_FULL   = LONG_W'(LONG_CYCLES);
  localparam logic [LONG_W-1:0]   LONG_LAST   = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0]   LONG_ONE    = LONG_W'(1);

  logic [SYNC_STAGES-1:0] syncChain;
  logic                   syncOut;
  logic [STABLE_W-1:0]    stableCnt;
  logic [LONG_W-1:0]      longCnt;
  logic                   level;
  logic                   pressPulse;
  logic                   releasePulse;
  logic                   longPulse;
  logic                   commit;

  assign syncOut = syncChain[SYNC_STAGES-1];
  assign commit  = (syncOut != level) && tick && (stableCnt == STABLE_LAST);

  // Shift the raw asynchronous input through the synchroniser every clock
  always_ff @(posedge clock) begin
    if (!reset) begin
      syncChain <= '0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], buttonPress};
    end
  end

  // Count ticks of continuous disagreement and commit the new level after a full window
  always_ff @(posedge clock) begin
    if (!reset) begin
      stableCnt    <= '0;
      level        <= 1'b0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
    end else begin
      pressPulse   <= commit && syncOut;
      releasePulse <= commit && !syncOut;
      if (syncOut == level) begin
        stableCnt <= '0;
      end else if (tick) begin
        if (commit) begin
          level     <= syncOut;
          stableCnt <= '0;
        end else begin
          stableCnt <= stableCnt + STABLE_ONE;
        end
      end
    end
  end

  // Measure how long the debounced level has been held and fire once at the threshold
  always_ff @(posedge clock) begin
    if (!reset) begin
      longCnt   <= '0;
      longPulse <= 1'b0;
    end else begin
      longPulse <= 1'b0;
      if (!level) begin
        longCnt <= '0;
      end else if (tick && (longCnt != LONG_FULL)) begin
        longCnt   <= longCnt + LONG_ONE;
        longPulse <= (longCnt == LONG_LAST);
      end
    end
  end

  assign chanOut.level        = level;
  assign chanOut.pressPulse   = pressPulse;
  assign chanOut.releasePulse = releasePulse;
  assign chanOut.longPulse    = longPulse;

endmodule

// File: rtl/debounce_multi.sv
// N independent button conditioners sharing one clock, reset and tick,
// with elaboration-time checks on the timing parameters.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tick,
  input  logic [N_CH-1:0] buttonPress,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pressPulse,
  output logic [N_CH-1:0] releasePulse,
  output logic [N_CH-1:0] longPulse
);

  chanOut_t chanOuts [N_CH];

  generate
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : gBadSync
      $error("debounce_multi: SYNC_STAGES must lie in 2..4");
    end
    if (STABLE_CYCLES < 2) begin : gBadStable
      $error("debounce_multi: STABLE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES <= STABLE_CYCLES) begin : gBadLong
      $error("debounce_multi: LONG_CYCLES must exceed STABLE_CYCLES");
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : gChannel
      debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LONG_CYCLES  (LONG_CYCLES)
      ) uChannel (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .buttonPress(buttonPress[ch]),
        .chanOut    (chanOuts[ch])
      );

      assign level[ch]        = chanOuts[ch].level;
      assign pressPulse[ch]   = chanOuts[ch].pressPulse;
      assign releasePulse[ch] = chanOuts[ch].releasePulse;
      assign longPulse[ch]    = chanOuts[ch].longPulse;
    end
  endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised bench for debounce_multi: every driven edge pushes the
// reference model's expected outputs into a queue that a free-running
// monitor pops and compares one clock later.
module tb_debounce_multi;

  localparam int N_CH          = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int LONG_CYCLES   = 10;

  typedef struct packed {
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic [N_CH-1:0] lng;
  } expect_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            tick  = 1'b1;
  logic [N_CH-1:0] buttonPress = '0;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] pressPulse;
  logic [N_CH-1:0] releasePulse;
  logic [N_CH-1:0] longPulse;

  int errors = 0;
  int checks = 0;

  expect_t         expQ [$];
  logic [N_CH-1:0] pipeQ [$];
  bit              mLevel [N_CH];
  int              mismatchTicks [N_CH];
  int              heldTicks [N_CH];

  logic [N_CH-1:0] curBtn = '0;
  int              holdLeft [N_CH];

  debounce_multi #(
    .N_CH         (N_CH),
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .LONG_CYCLES  (LONG_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .buttonPress (buttonPress),
    .level       (level),
    .pressPulse  (pressPulse),
    .releasePulse(releasePulse),
    .longPulse   (longPulse)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // Reference model: the raw input reaches the filter SYNC_STAGES edges
  // later; a level flips once the delayed input has disagreed with it for
  // STABLE_CYCLES consecutive ticks; a long pulse marks the tick on which
  // the held time reaches exactly LONG_CYCLES.
  task automatic modelEdge(input logic rstN, input logic tk, input logic [N_CH-1:0] btn);
    expect_t         e;
    logic [N_CH-1:0] seen;
    bit              oldLevel;
    e = '0;
    if (!rstN) begin
      pipeQ.delete();
      repeat (SYNC_STAGES) pipeQ.push_back('0);
      for (int ch = 0; ch < N_CH; ch++) begin
        mLevel[ch]        = 1'b0;
        mismatchTicks[ch] = 0;
        heldTicks[ch]     = 0;
      end
    end else begin
      seen = pipeQ.pop_front();
      pipeQ.push_back(btn);
      for (int ch = 0; ch < N_CH; ch++) begin
        oldLevel = mLevel[ch];
        if (!oldLevel) begin
          heldTicks[ch] = 0;
        end else if (tk) begin
          heldTicks[ch]++;
          if (heldTicks[ch] == LONG_CYCLES) e.lng[ch] = 1'b1;
        end
        if (seen[ch] == oldLevel) begin
          mismatchTicks[ch] = 0;
        end else if (tk) begin
          mismatchTicks[ch]++;
          if (mismatchTicks[ch] == STABLE_CYCLES) begin
            mLevel[ch]        = seen[ch];
            mismatchTicks[ch] = 0;
            if (seen[ch]) e.press[ch] = 1'b1;
            else          e.rel[ch]   = 1'b1;
          end
        end
        e.level[ch] = mLevel[ch];
      end
    end
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic rstN, input logic tk, input logic [N_CH-1:0] btn);
    reset       = rstN;
    tick        = tk;
    buttonPress = btn;
    modelEdge(rstN, tk, btn);
    @(posedge clock);
    #2;
  endtask

  // Random per-channel button activity mixing short bounces and long holds
  task automatic nextButtons();
    for (int ch = 0; ch < N_CH; ch++) begin
      if (holdLeft[ch] == 0) begin
        curBtn[ch]   = ~curBtn[ch];
        holdLeft[ch] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3))
                                                   : int'($urandom_range(5, 30));
      end else begin
        holdLeft[ch]--;
      end
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation after every edge
  initial begin
    expect_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("level",        32'(level),        32'(e.level));
        checkOutput("pressPulse",   32'(pressPulse),   32'(e.press));
        checkOutput("releasePulse", 32'(releasePulse), 32'(e.rel));
        checkOutput("longPulse",    32'(longPulse),    32'(e.lng));
      end
    end
  end

  // Stimulus: directed scenarios first, then randomised traffic
  initial begin
    int found;
    int longSeen;
    logic [N_CH-1:0] firstPress;

    repeat (3) applyStimulus(1'b0, 1'b1, '0);

    found = 0;
    for (int i = 1; (i <= 20) && (found == 0); i++) begin
      applyStimulus(1'b1, 1'b1, 4'b0001);
      if (pressPulse[0]) found = i;
    end
    checkOutput("pressLatency", 32'(found), 32'(SYNC_STAGES + STABLE_CYCLES));

    repeat (12) applyStimulus(1'b1, 1'b1, '0);

    firstPress = '0;
    for (int i = 0; (i < 20) && (firstPress == '0); i++) begin
      applyStimulus(1'b1, 1'b1, '1);
      firstPress = pressPulse;
    end
    checkOutput("simultaneousPress", 32'(firstPress), 32'hF);

    longSeen = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 1'b1, '1);
      longSeen += $countones(longPulse);
    end
    checkOutput("longPulseCount", 32'(longSeen), 32'(N_CH));

    applyStimulus(1'b0, 1'b1, '1);
    repeat (10) applyStimulus(1'b1, 1'b1, '1);
    repeat (12) applyStimulus(1'b1, 1'b1, '0);

    for (int ch = 0; ch < N_CH; ch++) holdLeft[ch] = int'($urandom_range(0, 10));
    curBtn = '0;
    for (int i = 0; i < 400; i++) begin
      nextButtons();
      applyStimulus(1'b1, ($urandom_range(0, 2) == 0), curBtn);
    end

    for (int i = 0; i < 2500; i++) begin
      nextButtons();
      applyStimulus(($urandom_range(0, 299) != 0), 1'b1, curBtn);
    end

    @(posedge clock);
    #3;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
